prog_imem: RTL and testbench
============================

PROG_IMEM -- requirements
Module: prog_imem

Interface
REQ-001 SHALL have parameter DATA_W, default 8: instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter NOP_WORD, default 0: word returned for unloaded or out-of-program reads.
REQ-004 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port Read_En, input, 1: fetch request.
REQ-007 SHALL have port Read_Address, input, ADDR_W: fetch address.
REQ-008 SHALL have port Instruction, output, DATA_W: registered fetch data.
REQ-009 SHALL have port Instr_Valid, output, 1: Instruction holds the result of a real fetch.
REQ-010 SHALL have port Load_Start, input, 1: begin program load.
REQ-011 SHALL have port Load_Valid, input, 1: Load_Data is valid this cycle.
REQ-012 SHALL have port Load_Data, input, DATA_W: next program word.
REQ-013 SHALL have port Load_Last, input, 1: qualifies the final word of a load.
REQ-014 SHALL have port Load_Ready, output, 1: block accepts a load word this cycle.
REQ-015 SHALL have port Prog_Ready, output, 1: a complete program is resident.
REQ-016 SHALL have port Prog_Len, output, ADDR_W+1: number of words in the resident program.
REQ-017 SHALL have port Load_Error, output, 1: sticky overflow flag for the last load.

Function
REQ-018 SHALL implement a state machine with states IDLE, LOAD and COMMIT.
REQ-019 IDLE -> LOAD SHALL occur on Load_Start=1; Load_Start SHALL be ignored in LOAD and COMMIT.
REQ-020 On entering LOAD, the block SHALL clear the write pointer, Prog_Len, Prog_Ready and Load_Error.
REQ-021 Load_Ready SHALL be 1 only in LOAD; a word is accepted when Load_Valid=1 and Load_Ready=1.
REQ-022 An accepted word SHALL be written to address = write pointer, after which the pointer increments by 1.
REQ-023 An accepted word with Load_Last=1 SHALL cause LOAD -> COMMIT; COMMIT -> IDLE SHALL follow unconditionally after one cycle.
REQ-024 In COMMIT, the block SHALL set Prog_Len = word count (including the last word) and Prog_Ready=1.
REQ-025 Words accepted while the pointer equals 2**ADDR_W SHALL be dropped, set Load_Error=1 and leave Prog_Len saturated at 2**ADDR_W.
REQ-026 Load_Last on an overflowed word SHALL still end the load normally via COMMIT.
REQ-027 A Read_En=1 in IDLE with Prog_Ready=1 SHALL, one cycle later, present Instruction=mem[Read_Address] and Instr_Valid=1.
REQ-028 In that case, if Read_Address >= Prog_Len, the block SHALL present NOP_WORD with Instr_Valid=1.
REQ-029 A Read_En=1 in LOAD or COMMIT, or with Prog_Ready=0, SHALL present NOP_WORD with Instr_Valid=0 one cycle later.
REQ-030 With Read_En=0, Instruction SHALL hold its value and Instr_Valid SHALL go to 0.
REQ-031 Fetch latency SHALL be exactly 1 cycle, with back-to-back fetches at one per cycle.
REQ-032 A read and a write to the same address in the same cycle SHALL NOT occur, because reads are suppressed during LOAD.

Reset
REQ-033 Reset_n=0 SHALL force state IDLE, Instruction=NOP_WORD, Instr_Valid=0, Prog_Ready=0, Prog_Len=0, Load_Error=0 and write pointer 0, asynchronously.
REQ-034 Memory array contents SHALL NOT be cleared by reset, but SHALL be unreachable until the next completed load because Prog_Ready=0.
REQ-035 Reset asserted mid-LOAD SHALL abort the load, with no COMMIT and Prog_Ready remaining 0.

Verification
REQ-036 Load 5 words 0x44,0x49,0x18,0x89,0xC2 (last word with Load_Last) -> Prog_Len=5, Prog_Ready=1 two cycles after the last word; fetch addr 3 -> 0x89, Instr_Valid=1 next cycle.
REQ-037 After the 5-word load, fetch addr 7 -> NOP_WORD with Instr_Valid=1; fetch before any load -> NOP_WORD with Instr_Valid=0.
REQ-038 With ADDR_W=2, load 6 words -> Load_Error=1, Prog_Len=4, mem[0..3] equal to the first 4 words.
REQ-039 Toggle Load_Valid 1/0 with Load_Ready stalls and Load_Start pulses during LOAD -> only valid-cycle words stored, no restart.
REQ-040 Assert Reset_n=0 after 2 of 5 load words -> all outputs at reset values immediately; a subsequent fetch gives Instr_Valid=0.
REQ-041 Issue fetches on addresses 0,1,2,3,4 on consecutive cycles -> five consecutive valid instructions with 1-cycle latency.

Source files
------------

// File: rtl/prog_imem.sv
// Program instruction memory: a streaming loader fills a word array, and the fetch
// port returns registered instructions once a complete program is resident.
module prog_imem #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Read_En,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] Instruction,
    output logic              Instr_Valid,
    input  logic              Load_Start,
    input  logic              Load_Valid,
    input  logic [DATA_W-1:0] Load_Data,
    input  logic              Load_Last,
    output logic              Load_Ready,
    output logic              Prog_Ready,
    output logic [ADDR_W:0]   Prog_Len,
    output logic              Load_Error
);

    localparam int            DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                ivld_q, ivld_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic                fetch_ok;
    logic                in_prog;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= NOP_WORD;
            ivld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            ivld_q  <= ivld_d;
        end
    end

    // Load sequencing; the pointer saturates at DEPTH so overflow words are dropped.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        ready_d = ready_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (Load_Start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (Load_Valid) begin
                    if (wptr_q == FULL) begin
                        err_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (Load_Last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                len_d   = wptr_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_we = (state_q == LOAD) && Load_Valid && (wptr_q != FULL);

    // Array is deliberately left out of reset; Prog_Ready gates all access to it.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[wptr_q[ADDR_W-1:0]] <= Load_Data;
        end
    end

    assign fetch_ok = (state_q == IDLE) && ready_q;
    assign in_prog  = ({1'b0, Read_Address} < len_q);

    always_comb begin
        instr_d = instr_q;
        ivld_d  = 1'b0;
        if (Read_En) begin
            if (fetch_ok) begin
                ivld_d  = 1'b1;
                instr_d = in_prog ? mem[Read_Address] : NOP_WORD;
            end else begin
                instr_d = NOP_WORD;
            end
        end
    end

    assign Instruction = instr_q;
    assign Instr_Valid = ivld_q;
    assign Load_Ready  = (state_q == LOAD);
    assign Prog_Ready  = ready_q;
    assign Prog_Len    = len_q;
    assign Load_Error  = err_q;

endmodule

// File: tb/tb_prog_imem.sv
// Bench for prog_imem: scoreboarded fetches on a default-size instance and
// overflow/reload sequences on a 4-word instance.
module tb_prog_imem;

    logic        Clk;
    logic        Reset_n;

    logic        Read_En;
    logic [7:0]  Read_Address;
    logic [7:0]  Instruction;
    logic        Instr_Valid;
    logic        Load_Start, Load_Valid, Load_Last;
    logic [7:0]  Load_Data;
    logic        Load_Ready, Prog_Ready, Load_Error;
    logic [8:0]  Prog_Len;

    logic        s_Read_En;
    logic [1:0]  s_Read_Address;
    logic [7:0]  s_Instruction;
    logic        s_Instr_Valid;
    logic        s_Load_Start, s_Load_Valid, s_Load_Last;
    logic [7:0]  s_Load_Data;
    logic        s_Load_Ready, s_Prog_Ready, s_Load_Error;
    logic [2:0]  s_Prog_Len;

    int checks = 0;
    int errors = 0;

    prog_imem #(.DATA_W(8), .ADDR_W(8), .NOP_WORD(8'h00)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Read_En(Read_En), .Read_Address(Read_Address),
        .Instruction(Instruction), .Instr_Valid(Instr_Valid),
        .Load_Start(Load_Start), .Load_Valid(Load_Valid),
        .Load_Data(Load_Data), .Load_Last(Load_Last),
        .Load_Ready(Load_Ready), .Prog_Ready(Prog_Ready),
        .Prog_Len(Prog_Len), .Load_Error(Load_Error)
    );

    prog_imem #(.DATA_W(8), .ADDR_W(2), .NOP_WORD(8'h00)) u_small (
        .Clk(Clk), .Reset_n(Reset_n),
        .Read_En(s_Read_En), .Read_Address(s_Read_Address),
        .Instruction(s_Instruction), .Instr_Valid(s_Instr_Valid),
        .Load_Start(s_Load_Start), .Load_Valid(s_Load_Valid),
        .Load_Data(s_Load_Data), .Load_Last(s_Load_Last),
        .Load_Ready(s_Load_Ready), .Prog_Ready(s_Prog_Ready),
        .Prog_Len(s_Prog_Len), .Load_Error(s_Load_Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] instr;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] instr;
        logic       vld;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [7:0] ei, input logic ev);
        exp_t e;
        Read_En      = 1'b1;
        Read_Address = a;
        e.addr  = a;
        e.instr = ei;
        e.vld   = ev;
        exp_q.push_back(e);
        step();
    endtask

    // Scoreboard: one response expected per cycle in which Read_En was sampled high.
    logic pend;
    always @(posedge Clk) begin
        exp_t e;
        pend = Read_En;
        #2;
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: response with no expected entry");
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("fetch_instr@%0h", e.addr), {24'd0, Instruction}, {24'd0, e.instr});
                chk($sformatf("fetch_vld@%0h", e.addr), {31'd0, Instr_Valid}, {31'd0, e.vld});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{8'd0,   8'h44, 1'b1};
        vt[1] = '{8'd1,   8'h49, 1'b1};
        vt[2] = '{8'd2,   8'h18, 1'b1};
        vt[3] = '{8'd3,   8'h89, 1'b1};
        vt[4] = '{8'd4,   8'hC2, 1'b1};
        vt[5] = '{8'd7,   8'h00, 1'b1};
        vt[6] = '{8'd255, 8'h00, 1'b1};
        vt[7] = '{8'd3,   8'h89, 1'b1};

        Reset_n = 1'b0;
        Read_En = 1'b0; Read_Address = '0;
        Load_Start = 1'b0; Load_Valid = 1'b0; Load_Last = 1'b0; Load_Data = '0;
        s_Read_En = 1'b0; s_Read_Address = '0;
        s_Load_Start = 1'b0; s_Load_Valid = 1'b0; s_Load_Last = 1'b0; s_Load_Data = '0;
        #1;
        chk("rst_instr", {24'd0, Instruction}, 32'h0);
        chk("rst_ivld", {31'd0, Instr_Valid}, 32'h0);
        chk("rst_prog_ready", {31'd0, Prog_Ready}, 32'h0);
        chk("rst_prog_len", {23'd0, Prog_Len}, 32'h0);
        chk("rst_load_err", {31'd0, Load_Error}, 32'h0);
        chk("rst_load_ready", {31'd0, Load_Ready}, 32'h0);
        step();
        Reset_n = 1'b1;
        step();

        // Fetch before any program is loaded
        fetch(8'd3, 8'h00, 1'b0);
        Read_En = 1'b0;
        step();

        // Load with valid gaps, a stray Load_Start and a fetch during LOAD
        Load_Start = 1'b1;
        step();
        Load_Start = 1'b0;
        chk("load_ready_in_load", {31'd0, Load_Ready}, 32'h1);
        chk("prog_ready_in_load", {31'd0, Prog_Ready}, 32'h0);
        Load_Valid = 1'b1; Load_Data = 8'h44;
        step();
        Load_Valid = 1'b0; Load_Data = 8'hEE; Load_Start = 1'b1;
        fetch(8'd0, 8'h00, 1'b0);
        Read_En = 1'b0; Load_Start = 1'b0;
        Load_Valid = 1'b1; Load_Data = 8'h49;
        step();
        Load_Data = 8'h18;
        step();
        Load_Valid = 1'b0; Load_Data = 8'hDD;
        step();
        Load_Valid = 1'b1; Load_Data = 8'h89;
        step();
        Load_Data = 8'hC2; Load_Last = 1'b1;
        step();
        Load_Valid = 1'b0; Load_Last = 1'b0;
        chk("commit_prog_ready", {31'd0, Prog_Ready}, 32'h0);
        chk("commit_load_ready", {31'd0, Load_Ready}, 32'h0);
        fetch(8'd3, 8'h00, 1'b0);
        Read_En = 1'b0;
        chk("prog_ready_after", {31'd0, Prog_Ready}, 32'h1);
        chk("prog_len_5", {23'd0, Prog_Len}, 32'd5);
        chk("load_err_clean", {31'd0, Load_Error}, 32'h0);

        // Back-to-back fetches from the table
        for (int i = 0; i < 8; i++) begin
            fetch(vt[i].addr, vt[i].instr, vt[i].vld);
        end
        Read_En = 1'b0;
        step();
        chk("hold_instr", {24'd0, Instruction}, 32'h89);
        chk("hold_ivld", {31'd0, Instr_Valid}, 32'h0);

        // Reset asserted partway through a load
        Load_Start = 1'b1;
        step();
        Load_Start = 1'b0;
        Load_Valid = 1'b1; Load_Data = 8'h11;
        step();
        Load_Data = 8'h22;
        step();
        Load_Valid = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("midrst_instr", {24'd0, Instruction}, 32'h0);
        chk("midrst_ivld", {31'd0, Instr_Valid}, 32'h0);
        chk("midrst_prog_ready", {31'd0, Prog_Ready}, 32'h0);
        chk("midrst_prog_len", {23'd0, Prog_Len}, 32'h0);
        chk("midrst_load_ready", {31'd0, Load_Ready}, 32'h0);
        chk("midrst_load_err", {31'd0, Load_Error}, 32'h0);
        step();
        Reset_n = 1'b1;
        step();
        fetch(8'd0, 8'h00, 1'b0);
        Read_En = 1'b0;
        step();
        chk("midrst_no_commit", {31'd0, Prog_Ready}, 32'h0);

        // Overflow on the 4-word instance
        s_Load_Start = 1'b1;
        step();
        s_Load_Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_Load_Valid = 1'b1;
            s_Load_Data  = 8'h10 + 8'(i);
            s_Load_Last  = (i == 5);
            step();
            if (i == 4) chk("ovf_err_sticky", {31'd0, s_Load_Error}, 32'h1);
        end
        s_Load_Valid = 1'b0; s_Load_Last = 1'b0;
        step();
        chk("ovf_err", {31'd0, s_Load_Error}, 32'h1);
        chk("ovf_len", {29'd0, s_Prog_Len}, 32'd4);
        chk("ovf_ready", {31'd0, s_Prog_Ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            s_Read_En = 1'b1;
            s_Read_Address = 2'(i);
            step();
            chk($sformatf("ovf_mem%0d", i), {24'd0, s_Instruction}, 32'h10 + i);
            chk($sformatf("ovf_vld%0d", i), {31'd0, s_Instr_Valid}, 32'h1);
        end
        s_Read_En = 1'b0;

        // Reload clears the error and shortens the program
        s_Load_Start = 1'b1;
        step();
        s_Load_Start = 1'b0;
        chk("reload_err_clr", {31'd0, s_Load_Error}, 32'h0);
        chk("reload_len_clr", {29'd0, s_Prog_Len}, 32'h0);
        s_Load_Valid = 1'b1; s_Load_Data = 8'hA0;
        step();
        s_Load_Data = 8'hA1; s_Load_Last = 1'b1;
        step();
        s_Load_Valid = 1'b0; s_Load_Last = 1'b0;
        step();
        chk("reload_len", {29'd0, s_Prog_Len}, 32'd2);
        chk("reload_err", {31'd0, s_Load_Error}, 32'h0);
        s_Read_En = 1'b1; s_Read_Address = 2'd1;
        step();
        chk("reload_mem1", {24'd0, s_Instruction}, 32'hA1);
        s_Read_Address = 2'd2;
        step();
        s_Read_En = 1'b0;
        chk("reload_oor_instr", {24'd0, s_Instruction}, 32'h0);
        chk("reload_oor_vld", {31'd0, s_Instr_Valid}, 32'h1);

        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
